// File: rtl/load_use_stall_ctrl.sv
// Load-use hazard controller beside ID: holds PC/IF-ID and bubbles ID/EX for LOAD_LAT cycles.
// Outputs are combinational on the current ID/EX view; flush aborts a stall, mem_busy freezes it.
module load_use_stall_ctrl #(
  parameter int unsigned     REG_AW      = 5,
  parameter int unsigned     OP_W        = 7,
  parameter logic [OP_W-1:0] LOAD_OP     = 7'b0000011,
  parameter int unsigned     LOAD_LAT    = 1,
  parameter bit              ZERO_EXEMPT = 1'b1,
  parameter int unsigned     CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              clear,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic              ex_valid,
  input  logic [OP_W-1:0]   ex_op,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              flush,
  input  logic              mem_busy,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              idex_bubble,
  output logic              stalling,
  output logic [CNT_W-1:0]  bubble_count
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  // The first bubble is issued from IDLE, so STALL covers the remaining LOAD_LAT-1 cycles.
  localparam logic [3:0] REM_INIT = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [3:0]       rem_q, rem_d;
  logic [CNT_W-1:0] bubble_count_q, bubble_count_d;

  logic ex_is_load;
  logic ex_rd_exempt;
  logic rs1_match;
  logic rs2_match;
  logic hazard;

  always_comb begin
    ex_is_load   = (ex_op == LOAD_OP);
    ex_rd_exempt = ZERO_EXEMPT && (ex_rd == '0);
    rs1_match    = rs1_used && (rs1 == ex_rd);
    rs2_match    = rs2_used && (rs2 == ex_rd);
    hazard       = id_valid && ex_valid && ex_is_load && !ex_rd_exempt
                   && (rs1_match || rs2_match);
  end

  always_comb begin
    idex_bubble = 1'b0;
    if (!flush && !mem_busy) begin
      idex_bubble = ((state_q == IDLE) && hazard) || (state_q == STALL);
    end
    pc_hold   = mem_busy || idex_bubble;
    ifid_hold = mem_busy || idex_bubble;
    stalling  = (state_q == STALL);
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (flush) begin
      state_d = IDLE;
      rem_d   = 4'd0;
    end else if (!mem_busy) begin
      unique case (state_q)
        IDLE: begin
          // With LOAD_LAT==1 the bubble now in EX clears the hazard by itself.
          if (hazard && (LOAD_LAT > 1)) begin
            state_d = STALL;
            rem_d   = REM_INIT;
          end
        end
        STALL: begin
          if (rem_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            rem_d = rem_q - 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          rem_d   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    bubble_count_d = bubble_count_q;
    if (idex_bubble && (bubble_count_q != '1)) begin
      bubble_count_d = bubble_count_q + CNT_ONE;
    end
  end

  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      state_q        <= IDLE;
      rem_q          <= 4'd0;
      bubble_count_q <= '0;
    end else begin
      state_q        <= state_d;
      rem_q          <= rem_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_load_use_stall_ctrl.sv
// Scoreboarded bench: three controller instances (LOAD_LAT 1/2/3) share one ID/EX stimulus.
module tb_load_use_stall_ctrl;

  logic       clk = 1'b0;
  logic       clear;
  logic       id_valid, rs1_used, rs2_used, ex_valid, flush, mem_busy;
  logic [4:0] rs1, rs2, ex_rd;
  logic [6:0] ex_op;

  logic        ph1, ih1, bub1, st1;
  logic [3:0]  cnt1;
  logic        ph2, ih2, bub2, st2;
  logic [15:0] cnt2;
  logic        ph3, ih3, bub3, st3;
  logic [15:0] cnt3;

  always #5 clk = ~clk;

  load_use_stall_ctrl #(.LOAD_LAT(1), .CNT_W(4)) dut1 (
    .CLK(clk), .clear(clear), .id_valid(id_valid), .rs1(rs1), .rs2(rs2),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_rd(ex_rd), .flush(flush), .mem_busy(mem_busy), .pc_hold(ph1),
    .ifid_hold(ih1), .idex_bubble(bub1), .stalling(st1), .bubble_count(cnt1));

  load_use_stall_ctrl #(.LOAD_LAT(2)) dut2 (
    .CLK(clk), .clear(clear), .id_valid(id_valid), .rs1(rs1), .rs2(rs2),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_rd(ex_rd), .flush(flush), .mem_busy(mem_busy), .pc_hold(ph2),
    .ifid_hold(ih2), .idex_bubble(bub2), .stalling(st2), .bubble_count(cnt2));

  load_use_stall_ctrl #(.LOAD_LAT(3)) dut3 (
    .CLK(clk), .clear(clear), .id_valid(id_valid), .rs1(rs1), .rs2(rs2),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_rd(ex_rd), .flush(flush), .mem_busy(mem_busy), .pc_hold(ph3),
    .ifid_hold(ih3), .idex_bubble(bub3), .stalling(st3), .bubble_count(cnt3));

  typedef struct packed {
    logic        ph;
    logic        ih;
    logic        bub;
    logic        stl;
    logic [15:0] cnt;
  } obs_t;

  typedef struct packed {
    logic       iv;
    logic       ev;
    logic [6:0] op;
    logic [4:0] rd;
    logic [4:0] r1;
    logic       u1;
    logic [4:0] r2;
    logic       u2;
    logic       fl;
    logic       mb;
  } stim_t;

  localparam stim_t HZ = '{iv:1'b1, ev:1'b1, op:7'b0000011, rd:5'd5, r1:5'd5, u1:1'b1,
                           r2:5'd0, u2:1'b0, fl:1'b0, mb:1'b0};
  localparam stim_t NB = '{iv:1'b1, ev:1'b0, op:7'b0000011, rd:5'd5, r1:5'd5, u1:1'b1,
                           r2:5'd0, u2:1'b0, fl:1'b0, mb:1'b0};
  localparam stim_t IDLE_IN = '{iv:1'b0, ev:1'b0, op:7'd0, rd:5'd0, r1:5'd0, u1:1'b0,
                                r2:5'd0, u2:1'b0, fl:1'b0, mb:1'b0};

  int   sel;
  obs_t obs;
  obs_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always_comb begin
    obs = '0;
    case (sel)
      1: obs = '{ph:ph1, ih:ih1, bub:bub1, stl:st1, cnt:{12'd0, cnt1}};
      2: obs = '{ph:ph2, ih:ih2, bub:bub2, stl:st2, cnt:cnt2};
      3: obs = '{ph:ph3, ih:ih3, bub:bub3, stl:st3, cnt:cnt3};
      default: obs = '0;
    endcase
  end

  function automatic obs_t exp_o(input logic hold, input logic bub, input logic stl, input int c);
    exp_o = '{ph:hold, ih:hold, bub:bub, stl:stl, cnt:16'(c)};
  endfunction

  task automatic apply(input stim_t s);
    id_valid = s.iv;  ex_valid = s.ev;  ex_op = s.op;   ex_rd = s.rd;
    rs1 = s.r1;       rs1_used = s.u1;  rs2 = s.r2;     rs2_used = s.u2;
    flush = s.fl;     mem_busy = s.mb;
  endtask

  task automatic do_clear();
    @(negedge clk);
    apply(IDLE_IN);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e, g;
    for (int d = 1; d <= 3; d++) begin
      sel = d;
      sb.push_back(exp_o(1'b0, 1'b0, 1'b0, 0));
      #1;
      e = sb.pop_front();
      g = obs;
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL reset dut%0d got %h want %h", d, g, e);
      end
    end
  endtask

  task automatic test_single_lat();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  e, g;
    do_clear();
    sel = 1;
    st = '{HZ, NB, NB};
    ex = '{exp_o(1, 1, 0, 0), exp_o(0, 0, 0, 1), exp_o(0, 0, 0, 1)};
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk);
      apply(st[i]);
      sb.push_back(ex[i]);
      #1;
      e = sb.pop_front();
      g = obs;
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL single_lat[%0d] got %h want %h", i, g, e);
      end
    end
  endtask

  task automatic test_multi_lat();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  e, g;
    do_clear();
    sel = 3;
    st = '{HZ, NB, NB, NB, NB};
    ex = '{exp_o(1, 1, 0, 0), exp_o(1, 1, 1, 1), exp_o(1, 1, 1, 2),
           exp_o(0, 0, 0, 3), exp_o(0, 0, 0, 3)};
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk);
      apply(st[i]);
      sb.push_back(ex[i]);
      #1;
      e = sb.pop_front();
      g = obs;
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL multi_lat[%0d] got %h want %h", i, g, e);
      end
    end
  endtask

  task automatic test_no_hazard();
    stim_t st[$];
    obs_t  ex[$];
    stim_t s;
    obs_t  e, g;
    do_clear();
    sel = 1;
    s = HZ; s.rd = 5'd0; s.u1 = 1'b0; s.r2 = 5'd0; s.u2 = 1'b1;  st.push_back(s);
    s = HZ; s.r1 = 5'd0; s.u1 = 1'b0; s.r2 = 5'd5; s.u2 = 1'b1;  // rs2 match, but unused below
    s.u2 = 1'b0;                                                st.push_back(s);
    s = HZ; s.op = 7'b0110011;                                  st.push_back(s);
    s = HZ; s.iv = 1'b0;                                        st.push_back(s);
    s = HZ; s.r1 = 5'd9;                                        st.push_back(s);
    s = HZ; s.r1 = 5'd0; s.u1 = 1'b0; s.r2 = 5'd5; s.u2 = 1'b1;  st.push_back(s);
    st.push_back(NB);
    ex = '{exp_o(0, 0, 0, 0), exp_o(0, 0, 0, 0), exp_o(0, 0, 0, 0), exp_o(0, 0, 0, 0),
           exp_o(0, 0, 0, 0), exp_o(1, 1, 0, 0), exp_o(0, 0, 0, 1)};
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk);
      apply(st[i]);
      sb.push_back(ex[i]);
      #1;
      e = sb.pop_front();
      g = obs;
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL no_hazard[%0d] got %h want %h", i, g, e);
      end
    end
  endtask

  task automatic test_flush();
    stim_t st[$];
    obs_t  ex[$];
    stim_t nbf, hzf;
    obs_t  e, g;
    do_clear();
    sel = 3;
    nbf = NB; nbf.fl = 1'b1;
    hzf = HZ; hzf.fl = 1'b1;
    st = '{HZ, nbf, NB, NB, hzf, NB};
    ex = '{exp_o(1, 1, 0, 0), exp_o(0, 0, 1, 1), exp_o(0, 0, 0, 1), exp_o(0, 0, 0, 1),
           exp_o(0, 0, 0, 1), exp_o(0, 0, 0, 1)};
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk);
      apply(st[i]);
      sb.push_back(ex[i]);
      #1;
      e = sb.pop_front();
      g = obs;
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL flush[%0d] got %h want %h", i, g, e);
      end
    end
  endtask

  task automatic test_mem_busy();
    stim_t st[$];
    obs_t  ex[$];
    stim_t nbm, hzm;
    obs_t  e, g;
    do_clear();
    sel = 2;
    nbm = NB; nbm.mb = 1'b1;
    hzm = HZ; hzm.mb = 1'b1;
    st = '{HZ, nbm, nbm, NB, NB, hzm, HZ, NB, NB};
    ex = '{exp_o(1, 1, 0, 0), exp_o(1, 0, 1, 1), exp_o(1, 0, 1, 1), exp_o(1, 1, 1, 1),
           exp_o(0, 0, 0, 2), exp_o(1, 0, 0, 2), exp_o(1, 1, 0, 2), exp_o(1, 1, 1, 3),
           exp_o(0, 0, 0, 4)};
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk);
      apply(st[i]);
      sb.push_back(ex[i]);
      #1;
      e = sb.pop_front();
      g = obs;
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL mem_busy[%0d] got %h want %h", i, g, e);
      end
    end
  endtask

  task automatic test_saturate();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  e, g;
    do_clear();
    sel = 1;
    for (int k = 0; k < 20; k++) begin
      st.push_back(HZ);
      ex.push_back(exp_o(1, 1, 0, (k < 15) ? k : 15));
      st.push_back(NB);
      ex.push_back(exp_o(0, 0, 0, (k + 1 < 15) ? k + 1 : 15));
    end
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk);
      apply(st[i]);
      sb.push_back(ex[i]);
      #1;
      e = sb.pop_front();
      g = obs;
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL saturate[%0d] got %h want %h", i, g, e);
      end
    end
  endtask

  task automatic test_clear_mid_stall();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  e, g;
    do_clear();
    sel = 3;
    st = '{HZ, NB, NB, NB};
    ex = '{exp_o(1, 1, 0, 0), exp_o(1, 1, 1, 1), exp_o(0, 0, 0, 0), exp_o(0, 0, 0, 0)};
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk);
      if (i == 2) clear = 1'b0;
      apply(st[i]);
      sb.push_back(ex[i]);
      #1;
      e = sb.pop_front();
      g = obs;
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL clear_mid_stall[%0d] got %h want %h", i, g, e);
      end
      if (i == 1) begin
        // Asynchronous clear well before the next rising edge.
        #2;
        clear = 1'b1;
        sb.push_back(exp_o(0, 0, 0, 0));
        #1;
        e = sb.pop_front();
        g = obs;
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL clear_async got %h want %h", g, e);
        end
      end
    end
  endtask

  initial begin
    clear = 1'b1;
    sel   = 1;
    apply(IDLE_IN);
    @(negedge clk);
    test_reset();
    clear = 1'b0;
    test_single_lat();
    test_multi_lat();
    test_no_hazard();
    test_flush();
    test_mem_busy();
    test_saturate();
    test_clear_mid_stall();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain left=%0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
